melody_sequencer: RTL and testbench

Plays a stored song on the electronic-keyboard datapath by walking an external song ROM and programming the square-wave tone divider. Each ROM entry carries a note code and a duration in beats; the block converts the note to the divider's 13-bit half-period count `k`, holds it for the note's duration, then inserts a short silent gap before the next note. It sits between the song ROM and the tone divider and supports start, stop, pause and optional looping. Divisor values assume a 1 MHz `clk`, where output tone frequency = 1e6 / (2·(k+1)).

---
 rtl/melody_sequencer.sv | 178 +++++++++++++++++
 tb/tb_melody_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Song player: walks a combinational song ROM and drives the tone divider; first note 2 cycles after start.
// No backpressure: pause freezes state and counters (mutes tone), stop aborts to IDLE.
module melody_sequencer #(
    parameter int unsigned BEAT_CYCLES = 250000,
    parameter int unsigned GAP_CYCLES  = 10000,
    parameter int unsigned ADDR_W      = 6,
    parameter bit          LOOP        = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    output logic [ADDR_W-1:0] song_addr,
    input  logic [6:0]        song_data,
    output logic [12:0]       k,
    output logic              tone_en,
    output logic [3:0]        note,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES != 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] song_addr_d;
    logic [12:0]       k_d;
    logic              tone_en_d;
    logic [3:0]        note_d;
    logic              done_d;
    logic [BW-1:0]     beat_cnt, beat_cnt_d;
    logic [2:0]        beats_rem, beats_rem_d;
    logic [GW-1:0]     gap_cnt, gap_cnt_d;
    logic              wrapped, wrapped_d;
    logic              sound, sound_d;
    logic [2:0]        dur;
    logic [3:0]        code;
    logic [12:0]       code_k;

    assign dur  = song_data[6:4];
    assign code = song_data[3:0];
    assign busy = (state != IDLE);

    // Half-period counts for a 1 MHz clock; rests and unused codes give 0.
    always_comb begin
        code_k = 13'd0;
        case (code)
            4'd1:    code_k = 13'd1910;
            4'd2:    code_k = 13'd1702;
            4'd3:    code_k = 13'd1516;
            4'd4:    code_k = 13'd1431;
            4'd5:    code_k = 13'd1275;
            4'd6:    code_k = 13'd1135;
            4'd7:    code_k = 13'd1011;
            4'd8:    code_k = 13'd955;
            default: code_k = 13'd0;
        endcase
    end

    always_comb begin
        state_d     = state;
        song_addr_d = song_addr;
        k_d         = k;
        note_d      = note;
        done_d      = 1'b0;
        beat_cnt_d  = beat_cnt;
        beats_rem_d = beats_rem;
        gap_cnt_d   = gap_cnt;
        wrapped_d   = wrapped;
        sound_d     = sound;

        if (stop) begin
            state_d     = IDLE;
            song_addr_d = '0;
            k_d         = 13'd0;
            note_d      = 4'd0;
            wrapped_d   = 1'b0;
            sound_d     = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_d     = LOAD;
                        song_addr_d = '0;
                        wrapped_d   = 1'b0;
                    end
                end
                LOAD: begin
                    if (!pause) begin
                        // A fetch after the last address counts as an end marker.
                        if (dur == 3'd0 || wrapped) begin
                            song_addr_d = '0;
                            wrapped_d   = 1'b0;
                            if (!LOOP) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                                k_d     = 13'd0;
                                note_d  = 4'd0;
                                sound_d = 1'b0;
                            end
                        end else begin
                            state_d     = PLAY;
                            k_d         = code_k;
                            note_d      = code;
                            sound_d     = (code_k != 13'd0);
                            beat_cnt_d  = BEAT_LAST;
                            beats_rem_d = dur;
                        end
                    end
                end
                PLAY: begin
                    if (!pause) begin
                        if (beat_cnt == '0) begin
                            if (beats_rem == 3'd1) begin
                                song_addr_d = song_addr + ADDR_W'(1);
                                wrapped_d   = (song_addr == {ADDR_W{1'b1}});
                                gap_cnt_d   = GAP_LAST;
                                state_d     = (GAP_CYCLES != 0) ? GAP : LOAD;
                            end else begin
                                beat_cnt_d  = BEAT_LAST;
                                beats_rem_d = beats_rem - 3'd1;
                            end
                        end else begin
                            beat_cnt_d = beat_cnt - BW'(1);
                        end
                    end
                end
                GAP: begin
                    if (!pause) begin
                        if (gap_cnt == '0) begin
                            state_d = LOAD;
                        end else begin
                            gap_cnt_d = gap_cnt - GW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Tone is registered so a pause mutes on the edge it is sampled.
        tone_en_d = (state_d == PLAY) && sound_d && !pause;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            song_addr <= '0;
            k         <= 13'd0;
            tone_en   <= 1'b0;
            note      <= 4'd0;
            done      <= 1'b0;
            beat_cnt  <= '0;
            beats_rem <= 3'd0;
            gap_cnt   <= '0;
            wrapped   <= 1'b0;
            sound     <= 1'b0;
        end else begin
            state     <= state_d;
            song_addr <= song_addr_d;
            k         <= k_d;
            tone_en   <= tone_en_d;
            note      <= note_d;
            done      <= done_d;
            beat_cnt  <= beat_cnt_d;
            beats_rem <= beats_rem_d;
            gap_cnt   <= gap_cnt_d;
            wrapped   <= wrapped_d;
            sound     <= sound_d;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: expected per-cycle output traces are built from the song rules.
module tb_melody_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, stop0, pause0, start1, stop1, pause1;
    logic [2:0]  addr0;
    logic [0:0]  addr1;
    logic [6:0]  data0, data1;
    logic [12:0] k0, k1;
    logic        ten0, ten1, busy0, busy1, done0, done1;
    logic [3:0]  note0, note1;
    logic [6:0]  rom0 [8];
    logic [6:0]  rom1 [2];

    assign data0 = rom0[addr0];
    assign data1 = rom1[addr1];

    melody_sequencer #(.BEAT_CYCLES(4), .GAP_CYCLES(2), .ADDR_W(3), .LOOP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .stop(stop0), .pause(pause0),
        .song_addr(addr0), .song_data(data0), .k(k0), .tone_en(ten0),
        .note(note0), .busy(busy0), .done(done0)
    );

    melody_sequencer #(.BEAT_CYCLES(3), .GAP_CYCLES(0), .ADDR_W(1), .LOOP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop1), .pause(pause1),
        .song_addr(addr1), .song_data(data1), .k(k1), .tone_en(ten1),
        .note(note1), .busy(busy1), .done(done1)
    );

    typedef struct packed {
        logic [5:0]  addr;
        logic [12:0] k;
        logic        ten;
        logic [3:0]  note;
        logic        busy;
        logic        done;
    } obs_t;

    obs_t tr[$];
    int   passed = 0;
    int   total  = 0;
    int   pz_at  = 0;
    int   pz_len = 0;
    int   st_at  = -1;

    function automatic logic [12:0] ref_k(input logic [3:0] c);
        case (c)
            4'd1: return 13'd1910;
            4'd2: return 13'd1702;
            4'd3: return 13'd1516;
            4'd4: return 13'd1431;
            4'd5: return 13'd1275;
            4'd6: return 13'd1135;
            4'd7: return 13'd1011;
            4'd8: return 13'd955;
            default: return 13'd0;
        endcase
    endfunction

    function automatic obs_t mk(input int a, input logic [12:0] kk, input logic t,
                                input logic [3:0] n, input logic b, input logic d);
        obs_t o;
        o.addr = 6'(a);
        o.k    = kk;
        o.ten  = t;
        o.note = n;
        o.busy = b;
        o.done = d;
        return o;
    endfunction

    function automatic obs_t sample(input int which);
        if (which == 1) return mk(int'(addr1), k1, ten1, note1, busy1, done1);
        return mk(int'(addr0), k0, ten0, note0, busy0, done0);
    endfunction

    // Expected trace: entry i sounds for dur*beat cycles, then gap cycles and one load cycle.
    task automatic build(input int which, input int limit);
        int          beat, gap, depth, a, dur;
        bit          lp;
        logic [12:0] ck, kk;
        logic [3:0]  cn, code;
        logic [6:0]  ent;
        obs_t        h;
        beat  = (which == 1) ? 3 : 4;
        gap   = (which == 1) ? 0 : 2;
        depth = (which == 1) ? 2 : 8;
        lp    = (which == 1);
        a  = 0;
        ck = 13'd0;
        cn = 4'd0;
        tr.delete();
        tr.push_back(mk(0, 13'd0, 1'b0, 4'd0, 1'b1, 1'b0));
        while (tr.size() < limit) begin
            if (a < depth) ent = (which == 1) ? rom1[a[0]] : rom0[a[2:0]];
            else ent = 7'd0;
            dur = int'(ent[6:4]);
            if (dur == 0) begin
                if (lp) begin
                    a = 0;
                    tr.push_back(mk(0, ck, 1'b0, cn, 1'b1, 1'b0));
                    continue;
                end
                tr.push_back(mk(0, 13'd0, 1'b0, 4'd0, 1'b0, 1'b1));
                repeat (3) tr.push_back(mk(0, 13'd0, 1'b0, 4'd0, 1'b0, 1'b0));
                break;
            end
            code = ent[3:0];
            kk   = ref_k(code);
            ck   = kk;
            cn   = code;
            repeat (dur * beat) tr.push_back(mk(a, kk, kk != 13'd0, code, 1'b1, 1'b0));
            a++;
            repeat (gap + 1) tr.push_back(mk(a % depth, kk, 1'b0, code, 1'b1, 1'b0));
        end
        // A pause window of n edges repeats the held cycle n times with the tone muted.
        if (pz_len > 0 && pz_at >= 1 && pz_at < tr.size()) begin
            if (tr[pz_at-1].busy) begin
                h = tr[pz_at-1];
                h.ten = 1'b0;
                repeat (pz_len) tr.insert(pz_at, h);
            end else begin
                pz_len = 0;
            end
        end else begin
            pz_len = 0;
        end
    endtask

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got addr=%0d k=%0d tone_en=%0b note=%0d busy=%0b done=%0b, expected addr=%0d k=%0d tone_en=%0b note=%0d busy=%0b done=%0b",
                   tag, got.addr, got.k, got.ten, got.note, got.busy, got.done,
                   exp.addr, exp.k, exp.ten, exp.note, exp.busy, exp.done);
        end
    endtask

    task automatic run_trace(input int which, input string tag, input int upto);
        int n;
        n = (upto < tr.size()) ? upto : tr.size();
        for (int t = 0; t < n; t++) begin
            if (which == 1) begin
                start1 = (t == 0);
            end else begin
                start0 = (t == 0) || (t > 0 && t == st_at && tr[t-1].busy);
                pause0 = (pz_len > 0) && (t >= pz_at) && (t < pz_at + pz_len);
            end
            @(posedge clk);
            #1;
            check(tag, sample(which), tr[t]);
        end
        start0 = 1'b0;
        pause0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic load_basic();
        for (int i = 0; i < 8; i++) rom0[i] = 7'h00;
        rom0[0] = 7'h11;
        rom0[1] = 7'h26;
    endtask

    obs_t zero;

    initial begin
        zero   = mk(0, 13'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        rst    = 1'b1;
        start0 = 1'b0; stop0 = 1'b0; pause0 = 1'b0;
        start1 = 1'b0; stop1 = 1'b0; pause1 = 1'b0;
        load_basic();
        rom1[0] = 7'h11;
        rom1[1] = 7'h12;
        repeat (2) @(posedge clk);
        #1;
        check("reset0", sample(0), zero);
        check("reset1", sample(1), zero);
        rst = 1'b0;

        build(0, 100000);
        run_trace(0, "basic", 100000);

        for (int i = 0; i < 8; i++) rom0[i] = 7'h00;
        rom0[0] = 7'h10;
        rom0[1] = 7'h1C;
        build(0, 100000);
        run_trace(0, "rest_invalid", 100000);

        load_basic();
        pz_at = 11; pz_len = 3;
        build(0, 100000);
        run_trace(0, "pause", 100000);
        pz_len = 0;

        build(0, 100000);
        run_trace(0, "pre_stop", 6);
        stop0 = 1'b1;
        @(posedge clk); #1;
        check("stop_idle", sample(0), zero);
        stop0 = 1'b0;
        @(posedge clk); #1;
        check("stop_no_done", sample(0), zero);
        run_trace(0, "replay_after_stop", 100000);

        start0 = 1'b1; stop0 = 1'b1;
        @(posedge clk); #1;
        check("stop_with_start", sample(0), zero);
        start0 = 1'b0; stop0 = 1'b0;

        run_trace(0, "pre_reset", 11);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_reset", sample(0), zero);
        rst = 1'b0;
        run_trace(0, "replay_after_reset", 100000);

        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < 8; i++) begin
                rom0[i][3:0] = 4'($urandom_range(0, 15));
                if (it % 4 != 0 && $urandom_range(0, 7) == 0) rom0[i][6:4] = 3'd0;
                else rom0[i][6:4] = 3'($urandom_range(1, 7));
            end
            pz_at  = $urandom_range(1, 60);
            pz_len = $urandom_range(0, 4);
            st_at  = $urandom_range(1, 80);
            build(0, 100000);
            run_trace(0, "random_song", 100000);
        end
        pz_len = 0;
        st_at  = -1;

        for (int it = 0; it < 3; it++) begin
            rom1[0] = {3'($urandom_range(1, 7)), 4'($urandom_range(0, 15))};
            rom1[1] = {3'($urandom_range(1, 7)), 4'($urandom_range(0, 15))};
            build(1, 150);
            run_trace(1, "loop_wrap", 150);
            stop1 = 1'b1;
            @(posedge clk); #1;
            check("loop_stop", sample(1), zero);
            stop1 = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
